// File: rtl/mem_march_driver.sv
// -----------------------------------------------------------------------------
// mem_march_driver
//
// Self-test bus master for a single-port RAM. On an accepted start it sweeps
// the whole array four times: write P(a) ascending, read back ascending, write
// ~P(a) descending, read back descending, where P(a) = seed ^ a. Every read is
// compared one cycle later against the expected word. It reports pass/fail, a
// saturating mismatch count and the address of the first mismatch.
//
// Ports
//   clk_ip            : clock, all state changes on the rising edge
//   rst_ip            : synchronous active-high reset
//   start_ip          : run request, only looked at while idle
//   seed_ip           : pattern seed, captured when a start is accepted
//   rd_data_ip        : RAM read data, valid the cycle after a read
//   mem_we_op         : RAM write enable
//   mem_cs_op         : RAM chip select
//   mem_oe_op         : RAM output enable
//   mem_address_op    : RAM address
//   mem_data_op       : RAM write data (0 when not writing)
//   busy_op           : run in progress
//   done_op           : one-cycle pulse when a run finishes
//   pass_op           : last run finished with zero mismatches
//   err_count_op      : mismatch count, saturating
//   first_err_addr_op : address of the first mismatch of the run
// -----------------------------------------------------------------------------
module mem_march_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_ip,
    input  logic                  rst_ip,
    input  logic                  start_ip,
    input  logic [DATA_WIDTH-1:0] seed_ip,
    input  logic [DATA_WIDTH-1:0] rd_data_ip,
    output logic                  mem_we_op,
    output logic                  mem_cs_op,
    output logic                  mem_oe_op,
    output logic [ADDR_WIDTH-1:0] mem_address_op,
    output logic [DATA_WIDTH-1:0] mem_data_op,
    output logic                  busy_op,
    output logic                  done_op,
    output logic                  pass_op,
    output logic [ADDR_WIDTH:0]   err_count_op,
    output logic [ADDR_WIDTH-1:0] first_err_addr_op
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RD0,
        S_WR1,
        S_RD1,
        S_FLUSH,
        S_DONE
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ERR_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   ERR_MAX   = '1;

    // Address is zero-extended or truncated to the word width.
    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [DATA_WIDTH-1:0] seed,
        input logic [ADDR_WIDTH-1:0] addr
    );
        return seed ^ DATA_WIDTH'(addr);
    endfunction

    // The state register always describes the operation currently on the bus;
    // the bus registers are loaded from the next state so they line up.
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic                  we_q, we_d;
    logic                  cs_q, cs_d;
    logic                  oe_q, oe_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH:0]   err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;

    // One-deep compare pipeline: what the read on the bus this cycle expects.
    logic                  pend_valid_q, pend_valid_d;
    logic [DATA_WIDTH-1:0] pend_exp_q, pend_exp_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  mismatch;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        seed_d      = seed_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;

        // Compare runs regardless of state, so the last RD0 read is checked
        // during the first WR1 cycle and the last RD1 read during FLUSH.
        mismatch = pend_valid_q && (rd_data_ip != pend_exp_q);
        if (mismatch) begin
            if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + ERR_ONE;
            end
            if (err_count_q == '0) begin
                first_err_d = pend_addr_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (start_ip) begin
                    state_d     = S_WR0;
                    seed_d      = seed_ip;
                    err_count_d = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                end
            end
            S_WR0: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_RD0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_RD0: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_WR1;
                    addr_d  = LAST_ADDR;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_WR1: begin
                if (addr_q == '0) begin
                    state_d = S_RD1;
                    addr_d  = LAST_ADDR;
                end else begin
                    addr_d = addr_q - ADDR_ONE;
                end
            end
            S_RD1: begin
                if (addr_q == '0) begin
                    state_d = S_FLUSH;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q - ADDR_ONE;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
                addr_d  = '0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase

        // The final compare resolves on the same edge that enters DONE, so
        // the verdict uses the updated count.
        if (state_d == S_DONE) begin
            pass_d = (err_count_d == '0);
        end

        we_d   = (state_d == S_WR0) || (state_d == S_WR1);
        oe_d   = (state_d == S_RD0) || (state_d == S_RD1);
        cs_d   = we_d || oe_d;
        data_d = '0;
        if (state_d == S_WR0) begin
            data_d = pattern(seed_d, addr_d);
        end else if (state_d == S_WR1) begin
            data_d = ~pattern(seed_d, addr_d);
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);

        pend_valid_d = oe_q;
        pend_addr_d  = addr_q;
        pend_exp_d   = (state_q == S_RD1) ? ~pattern(seed_q, addr_q)
                                          : pattern(seed_q, addr_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_ip) begin
        if (rst_ip) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            seed_q       <= '0;
            we_q         <= 1'b0;
            cs_q         <= 1'b0;
            oe_q         <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            first_err_q  <= '0;
            // NOTE: clearing the valid bit is what discards an in-flight
            // compare; the payload is reset only to keep it deterministic.
            pend_valid_q <= 1'b0;
            pend_exp_q   <= '0;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            seed_q       <= seed_d;
            we_q         <= we_d;
            cs_q         <= cs_d;
            oe_q         <= oe_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            first_err_q  <= first_err_d;
            pend_valid_q <= pend_valid_d;
            pend_exp_q   <= pend_exp_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign mem_we_op         = we_q;
    assign mem_cs_op         = cs_q;
    assign mem_oe_op         = oe_q;
    assign mem_address_op    = addr_q;
    assign mem_data_op       = data_q;
    assign busy_op           = busy_q;
    assign done_op           = done_q;
    assign pass_op           = pass_q;
    assign err_count_op      = err_count_q;
    assign first_err_addr_op = first_err_q;

endmodule

// File: tb/tb_mem_march_driver.sv
// -----------------------------------------------------------------------------
// tb_mem_march_driver
//
// Two instances share one clock: a 1024-word driver and a 16-word driver, each
// with its own behavioural RAM that can inject stuck-at faults on read. A table
// of complete runs is applied in a loop, followed by hand-written sequences for
// start held through DONE and reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_mem_march_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_r;
    logic       start_r;
    logic       sel16;
    logic [7:0] seed_r;
    int         fault_mode;

    // 1024-word instance (a) and 16-word instance (b).
    logic       start_a, start_b;
    logic [7:0] rd_a = '0, rd_b = '0;
    logic       we_a, cs_a, oe_a, busy_a, done_a, pass_a;
    logic [9:0] addr_a, ferr_a;
    logic [7:0] data_a;
    logic [10:0] err_a;
    logic       we_b, cs_b, oe_b, busy_b, done_b, pass_b;
    logic [3:0] addr_b, ferr_b;
    logic [7:0] data_b;
    logic [4:0] err_b;

    assign start_a = start_r & ~sel16;
    assign start_b = start_r & sel16;

    mem_march_driver #(.DATA_WIDTH(8), .RAM_DEPTH(1024)) u_dut (
        .clk_ip(clk), .rst_ip(rst_r), .start_ip(start_a), .seed_ip(seed_r),
        .rd_data_ip(rd_a), .mem_we_op(we_a), .mem_cs_op(cs_a), .mem_oe_op(oe_a),
        .mem_address_op(addr_a), .mem_data_op(data_a), .busy_op(busy_a),
        .done_op(done_a), .pass_op(pass_a), .err_count_op(err_a),
        .first_err_addr_op(ferr_a)
    );

    mem_march_driver #(.DATA_WIDTH(8), .RAM_DEPTH(16)) u_dut16 (
        .clk_ip(clk), .rst_ip(rst_r), .start_ip(start_b), .seed_ip(seed_r),
        .rd_data_ip(rd_b), .mem_we_op(we_b), .mem_cs_op(cs_b), .mem_oe_op(oe_b),
        .mem_address_op(addr_b), .mem_data_op(data_b), .busy_op(busy_b),
        .done_op(done_b), .pass_op(pass_b), .err_count_op(err_b),
        .first_err_addr_op(ferr_b)
    );

    // View of whichever instance the current test drives.
    logic       we_s, cs_s, oe_s, busy_s, done_s, pass_s;
    logic [7:0] data_s;
    int         addr_s, err_s, ferr_s;
    always_comb begin
        we_s   = sel16 ? we_b   : we_a;
        cs_s   = sel16 ? cs_b   : cs_a;
        oe_s   = sel16 ? oe_b   : oe_a;
        busy_s = sel16 ? busy_b : busy_a;
        done_s = sel16 ? done_b : done_a;
        pass_s = sel16 ? pass_b : pass_a;
        data_s = sel16 ? data_b : data_a;
        addr_s = sel16 ? int'(addr_b) : int'(addr_a);
        err_s  = sel16 ? int'(err_b)  : int'(err_a);
        ferr_s = sel16 ? int'(ferr_b) : int'(ferr_a);
    end

    // RAM models: mode 1 = bit 0 stuck at 1 at address 5,
    //             mode 2 = bit 0 stuck at 0 at addresses 7 and 9.
    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [16];

    function automatic logic [7:0] faulty(input logic [7:0] d, input int a);
        if (fault_mode == 1 && a == 5) return d | 8'h01;
        if (fault_mode == 2 && (a == 7 || a == 9)) return d & 8'hFE;
        return d;
    endfunction

    always @(posedge clk) begin
        if (cs_a && we_a) mem_a[addr_a] <= data_a;
        if (cs_a && oe_a) rd_a <= faulty(mem_a[addr_a], int'(addr_a));
        if (cs_b && we_b) mem_b[addr_b] <= data_b;
        if (cs_b && oe_b) rd_b <= faulty(mem_b[addr_b], int'(addr_b));
    end

    // Bus monitor: encoding legality on both instances, and capture of the
    // two writes to address 3 on the selected instance.
    int         proto_bad = 0;
    int         wr3_cnt = 0;
    logic [7:0] wr3_first = '0, wr3_second = '0;
    always @(negedge clk) begin
        if ((we_a && oe_a) || (we_a && !cs_a) || (oe_a && !cs_a)) proto_bad++;
        if ((we_b && oe_b) || (we_b && !cs_b) || (oe_b && !cs_b)) proto_bad++;
        if (we_s && addr_s == 3) begin
            if (wr3_cnt == 0) wr3_first = data_s;
            else              wr3_second = data_s;
            wr3_cnt++;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // One complete run: start pulse, count cycles from the accepting edge to
    // the done pulse, then watch a tail for any further done pulses.
    task automatic run(input bit s16, input logic [7:0] seed, input int restart_at,
                       output int cycles, output int dones);
        sel16   = s16;
        seed_r  = seed;
        wr3_cnt = 0;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                start_r = 1'b0;
                check("busy_first_cycle", int'(busy_s), 1);
            end
            if (restart_at != 0 && cycles == restart_at)     start_r = 1'b1;
            if (restart_at != 0 && cycles == restart_at + 1) start_r = 1'b0;
        end while (!done_s && cycles < 5000);
        dones = done_s ? 1 : 0;
        check("busy_at_done", int'(busy_s), 0);
        repeat (70) begin
            @(negedge clk);
            if (done_s) dones++;
        end
    endtask

    typedef struct {
        bit         s16;
        logic [7:0] seed;
        int         fault;
        int         restart_at;
        int         exp_cycles;
        int         exp_pass;
        int         exp_err;
        int         exp_ferr;
        logic [7:0] exp_w3a;
        logic [7:0] exp_w3b;
    } vec_t;

    vec_t vt[6];

    initial begin
        int cyc, dn, n, d1, d2, bad;

        vt[0] = '{1'b0, 8'h00, 0,  0, 4098, 1, 0, 0, 8'h03, 8'hFC};
        vt[1] = '{1'b0, 8'hA5, 0,  0, 4098, 1, 0, 0, 8'hA6, 8'h59};
        vt[2] = '{1'b0, 8'h00, 1,  0, 4098, 0, 1, 5, 8'h03, 8'hFC};
        vt[3] = '{1'b1, 8'h00, 2,  0,   66, 0, 2, 7, 8'h03, 8'hFC};
        vt[4] = '{1'b1, 8'h3C, 0, 50,   66, 1, 0, 0, 8'h3F, 8'hC0};
        vt[5] = '{1'b1, 8'h00, 1,  0,   66, 0, 1, 5, 8'h03, 8'hFC};

        rst_r = 1'b1; start_r = 1'b0; sel16 = 1'b0; seed_r = 8'h00; fault_mode = 0;
        repeat (3) @(negedge clk);
        check("reset_bus", int'({we_a, cs_a, oe_a}), 0);
        check("reset_addr_data", int'({addr_a, data_a}), 0);
        check("reset_status", int'({busy_a, done_a, pass_a}), 0);
        check("reset_err", int'(err_a), 0);
        check("reset_ferr", int'(ferr_a), 0);
        rst_r = 1'b0;

        for (int i = 0; i < 6; i++) begin
            fault_mode = vt[i].fault;
            run(vt[i].s16, vt[i].seed, vt[i].restart_at, cyc, dn);
            check($sformatf("v%0d_cycles", i), cyc, vt[i].exp_cycles);
            check($sformatf("v%0d_dones", i), dn, 1);
            check($sformatf("v%0d_pass", i), int'(pass_s), vt[i].exp_pass);
            check($sformatf("v%0d_err", i), err_s, vt[i].exp_err);
            check($sformatf("v%0d_ferr", i), ferr_s, vt[i].exp_ferr);
            check($sformatf("v%0d_wr3_count", i), wr3_cnt, 2);
            check($sformatf("v%0d_wr3_wr0", i), int'(wr3_first), int'(vt[i].exp_w3a));
            check($sformatf("v%0d_wr3_wr1", i), int'(wr3_second), int'(vt[i].exp_w3b));
            check($sformatf("v%0d_protocol", i), proto_bad, 0);
        end
        fault_mode = 0;

        // Start held high through DONE: a second run begins from the IDLE
        // cycle after DONE, so the second done lands 67 cycles after the first.
        sel16 = 1'b1; seed_r = 8'h42;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        n = 0; d1 = 0; d2 = 0;
        do begin
            @(negedge clk);
            n++;
            if (done_s) begin
                if (d1 == 0) d1 = n;
                else         d2 = n;
            end
            if (d2 != 0) start_r = 1'b0;
        end while (d2 == 0 && n < 400);
        start_r = 1'b0;
        check("held_start_done1", d1, 66);
        check("held_start_done2", d2, 133);
        check("held_start_pass", int'(pass_s), 1);
        repeat (3) @(negedge clk);

        // Reset at cycle 100 of a 1024-word run.
        sel16 = 1'b0; seed_r = 8'h11;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start_r = 1'b0;
        end while (n < 100);
        check("pre_rst_busy", int'(busy_a), 1);
        rst_r = 1'b1;
        @(negedge clk);
        check("rst_bus", int'({we_a, cs_a, oe_a}), 0);
        check("rst_addr", int'(addr_a), 0);
        check("rst_data", int'(data_a), 0);
        check("rst_status", int'({busy_a, done_a, pass_a}), 0);
        check("rst_err_ferr", int'({err_a, ferr_a}), 0);
        rst_r = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a || busy_a) bad++;
        end
        check("rst_no_done", bad, 0);

        run(1'b0, 8'h77, 0, cyc, dn);
        check("post_rst_cycles", cyc, 4098);
        check("post_rst_dones", dn, 1);
        check("post_rst_pass", int'(pass_a), 1);
        check("post_rst_err", int'(err_a), 0);
        check("final_protocol", proto_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
